// File: rtl/axi_pkg.sv
// Shared AXI read-side encodings and FSM state type for the SRAM read slave.
// Provides burst/response codes, the slave state enum and a WRAP length check.
// Pure declarations: no logic, no latency, no flow control.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // WRAP is only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_sram_rd_slave_if.sv
// AXI4 read address (AR) and read data (R) channel bundle.
// Ports: ar* request from master, r* response from slave, rready from master.
// master modport drives AR and rready; slave modport drives arready and R.
interface axi_sram_rd_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_rd_fifo2.sv
// Two-entry fall-through FIFO for read data plus {last, resp} tag.
// Latency: a push into an empty FIFO is visible on the head in the same cycle.
// Backpressure: head holds until pop; caller must never push into a full FIFO.
// Ports: push/push_dat in, pop in, head_vld/head_dat out, count = stored entries.
module axi_rd_fifo2 #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         head_vld,
  output logic [W-1:0] head_dat,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         empty;
  logic         pass;
  logic         store;
  logic         adv;

  assign empty    = (count == 2'd0);
  assign head_vld = !empty || push;
  // Zero when nothing is presented so the R bus idles at zero.
  assign head_dat = !empty ? mem[rd_ptr] : (push ? push_dat : '0);

  // Empty FIFO with push and pop in the same cycle: data flows straight through.
  assign pass  = empty && push && pop;
  assign store = push && !pass;
  assign adv   = pop && !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= !wr_ptr;
      end
      if (adv) begin
        rd_ptr <= !rd_ptr;
      end
      count <= count + {1'b0, store} - {1'b0, adv};
    end
  end

endmodule

// File: rtl/axi_sram_rd_slave.sv
// AXI4 read slave serving one burst at a time from a 1-cycle-latency SRAM.
// Latency: AR handshake at T, sram_en at T+1, first rvalid at T+2; 1 beat/cycle.
// Backpressure: R held stable while stalled; SRAM reads credit-gated to 2 in flight.
// Ports: clk, resetn; axi (AR/R slave modport); sram_en/sram_addr out, sram_rdata in.
module axi_sram_rd_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int SRAM_AW = 14
) (
  input  logic                 clk,
  input  logic                 resetn,
  axi_sram_rd_slave_if.slave   axi,
  output logic                 sram_en,
  output logic [SRAM_AW-1:0]   sram_addr,
  input  logic [DATA_W-1:0]    sram_rdata
);

  localparam int BYTE_SH = $clog2(DATA_W / 8);

  rd_state_e         state;
  rd_state_e         state_nxt;

  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic              inflight_q;
  logic              inflight_last_q;

  logic              ar_ok;
  logic              ar_hs;
  logic              issue;
  logic              pop;
  logic              beat_last;
  logic              wrap_ok;
  logic              ar_err;
  logic [1:0]        ar_burst_eff;

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_nxt;

  logic [1:0]        fifo_count;
  logic              head_vld;
  logic [DATA_W+2:0] head_dat;
  logic [DATA_W+2:0] push_dat;

  assign pop       = head_vld && axi.rready;
  assign beat_last = (cnt_q == len_q);
  assign ar_hs     = axi.arvalid && ar_ok;

  // Request decode: illegal WRAP lengths and the reserved code run as INCR with SLVERR.
  assign wrap_ok = wrap_len_ok(axi.arlen);
  assign ar_err  = (axi.arburst == BURST_RSVD)
                || (int'(axi.arsize) > BYTE_SH)
                || ((axi.arburst == BURST_WRAP) && !wrap_ok);

  always_comb begin
    ar_burst_eff = BURST_INCR;
    if (axi.arburst == BURST_FIXED) begin
      ar_burst_eff = BURST_FIXED;
    end else if ((axi.arburst == BURST_WRAP) && wrap_ok) begin
      ar_burst_eff = BURST_WRAP;
    end
  end

  // Beat address generation; WRAP keeps the upper bits of the aligned window.
  assign step      = ADDR_W'(1) << size_q;
  assign wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
  assign addr_inc  = addr_q + step;

  always_comb begin
    addr_nxt = addr_inc;
    if (burst_q == BURST_FIXED) begin
      addr_nxt = addr_q;
    end else if (burst_q == BURST_WRAP) begin
      addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
    end
  end

  // FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ar_ok     = 1'b0;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        ar_ok = (fifo_count == 2'd0) && !inflight_q;
        if (axi.arvalid && ar_ok) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Stored entries plus the read in flight must leave room in the FIFO.
        issue = ({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2;
        if (issue && beat_last) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && head_dat[DATA_W+2]) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Burst context and SRAM read pipeline
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_q            <= '0;
      addr_q          <= '0;
      len_q           <= 8'd0;
      cnt_q           <= 8'd0;
      size_q          <= 3'd0;
      burst_q         <= BURST_INCR;
      err_q           <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (ar_hs) begin
        id_q    <= axi.arid;
        addr_q  <= axi.araddr;
        len_q   <= axi.arlen;
        size_q  <= axi.arsize;
        burst_q <= ar_burst_eff;
        err_q   <= ar_err;
        cnt_q   <= 8'd0;
      end else if (issue) begin
        addr_q <= addr_nxt;
        cnt_q  <= cnt_q + 8'd1;
      end
      inflight_q <= issue;
      if (issue) begin
        inflight_last_q <= beat_last;
      end
    end
  end

  assign sram_en   = issue;
  assign sram_addr = issue ? SRAM_AW'(addr_q >> BYTE_SH) : '0;

  assign push_dat = {inflight_last_q, (err_q ? RESP_SLVERR : RESP_OKAY), sram_rdata};

  axi_rd_fifo2 #(
    .W (DATA_W + 3)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (inflight_q),
    .push_dat (push_dat),
    .pop      (pop),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  assign axi.arready = ar_ok;
  assign axi.rvalid  = head_vld;
  assign axi.rdata   = head_dat[DATA_W-1:0];
  assign axi.rresp   = head_dat[DATA_W+1:DATA_W];
  assign axi.rlast   = head_dat[DATA_W+2];
  assign axi.rid     = id_q;

endmodule

// File: doc/axi_sram_rd_slave.md
Name: axi_sram_rd_slave

Overview:
AXI4 read-channel responder (AR/R) that serves the read requests of the bridge's CPU-side initiator from a single-port synchronous SRAM with 1-cycle read latency. It sits between the AXI interconnect/initiator and the SRAM macro. It accepts one burst at a time, generates beat addresses (FIXED/INCR/WRAP), and returns data on R with full rready backpressure support. Sustained throughput is one beat per cycle.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI/SRAM data width (bytes per beat = DATA_W/8)
ID_W, 4, AXI ID width
SRAM_AW, 14, SRAM word-address width

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
arid  in  ID_W  read request ID
araddr  in  ADDR_W  byte start address
arlen  in  8  beats minus 1
arsize  in  3  log2 bytes per beat
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
arvalid  in  1  request valid
arready  out  1  request accepted
rid  out  ID_W  echo of latched arid
rdata  out  DATA_W  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final beat of burst
rvalid  out  1  R beat valid
rready  in  1  initiator accepts beat
sram_en  out  1  SRAM read strobe
sram_addr  out  SRAM_AW  SRAM word address
sram_rdata  in  DATA_W  SRAM data, valid the cycle after sram_en

Behaviour:
- Reset (async, resetn=0): state IDLE, arready=1, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, sram_en=0, sram_addr=0; FIFO emptied, in-flight flag cleared. Reset mid-burst drops the burst; rvalid falls immediately.
- States: IDLE, ISSUE, DRAIN.
- IDLE: arready=1 only when FIFO empty and no SRAM read in flight. On arvalid&&arready latch id, addr, len, size, burst; beat counter=0; error flag = (arburst==11) || (arsize > log2(DATA_W/8)); go ISSUE.
- ISSUE: sram_en=1 when (fifo_count + inflight) < 2; sram_addr = current byte addr >> log2(DATA_W/8), truncated to SRAM_AW. Each issue advances the counter and the address: FIXED holds; INCR adds 1<<size; WRAP adds 1<<size and wraps within aligned window of (len+1)<<size bytes (len must be 1,3,7,15, otherwise treated as INCR with SLVERR). Reserved burst is handled as INCR with SLVERR. After issuing beat len go DRAIN.
- The cycle after sram_en, sram_rdata is pushed into a 2-entry FIFO with tag {last, resp}. FIFO head drives rvalid/rdata/rresp/rlast; rid holds the latched ID. Pop on rvalid&&rready.
- DRAIN: no issues; return to IDLE when the last beat is popped (rvalid&&rready&&rlast). arready rises in the cycle after that pop.
- Latency: AR handshake at cycle T -> sram_en at T+1 -> rvalid at T+2. With rready held high, beats go out back-to-back; rlast is asserted on beat len only.
- Backpressure: while rvalid&&!rready, rdata/rresp/rlast/rid stay stable. The FIFO never overflows because issues are credit-gated.
- Single beat (arlen=0): rlast is set on the only beat.
- Address arithmetic is modulo 2^ADDR_W; a 4KB-crossing INCR is not checked (the initiator owns that rule).

Decomposition:
- Package axi_pkg: burst codes (BURST_FIXED/INCR/WRAP), resp codes (RESP_OKAY/SLVERR), state enum.
- Sub-module axi_rd_fifo2: 2-entry data+tag FIFO with count output, push/pop in the same cycle allowed.

Test Plan:
- Reset then araddr=0x0, arlen=0, INCR, size=2, SRAM[0]=0xDEADBEEF, rready=1 -> sram_en at T+1, rvalid+rlast with rdata=0xDEADBEEF, rresp=00 at T+2; arready back high the following cycle.
- INCR arlen=3 from 0x10, rready=1 -> sram_addr 4,5,6,7 on consecutive cycles; 4 back-to-back beats; rlast on the 4th; rid equals arid=0xA.
- WRAP arlen=3 from 0x38 -> word order 14,15,12,13; rlast on 13; rresp=00.
- INCR arlen=7 with rready toggling 1,0,0,1 -> no beat lost or duplicated; data stable while stalled; never more than 2 SRAM reads outstanding.
- arburst=11 arlen=1 -> 2 beats, both rresp=10, rlast on the 2nd; arsize=3 with DATA_W=32 -> rresp=10.
- resetn pulsed low mid-burst (beat 2 of 8) -> rvalid=0 immediately, arready=1 after release, and the next request completes normally.
